inject_arbiter: RTL
===================

Name: inject_arbiter

Overview:
- Shares the local flit-building/injection path among NUM_REQ local requesters (PE ports, collective engines).
- Each cycle, selects at most one pending request by round-robin and assembles an 82-bit flit, stamping the node's own coordinates as source.
- Holds the flit in a one-entry output register with a valid/ready handshake toward the router injection FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, 2, round-robin pointer width; must equal clog2(NUM_REQ).
- REQ_W, 72, width of one request bundle (fixed, not user-tunable).
- FLIT_W, 82, flit width (fixed).
- CNT_W, 16, width of the injected-flit statistics counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- arb_en  in  1  when 0, no new grants; a pending output flit still drains.
- my_x, my_y, my_z  in  3 each  local node coordinates, sampled at grant.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_bundle  in  NUM_REQ*REQ_W  requester i occupies bits [i*72+71 : i*72].
  - [31:0] payload, [35:32] op, [37:36] algtype, [45:38] tag, [53:46] contextId, [62:54] rank.
  - [65:63] dst_x, [68:66] dst_y, [71:69] dst_z.
- req_grant  out  NUM_REQ  one-hot or zero, combinational; the transfer occurs on the edge where req_valid[i]&req_grant[i].
- out_flit  out  82  registered flit.
- out_valid  out  1  out_flit holds a flit.
- out_ready  in  1  downstream accepts; the transfer occurs on the edge where out_valid&out_ready.
- flit_count  out  CNT_W  number of flits accepted downstream.

Behaviour:
- Reset values (rst=1 at a clk edge): out_valid=0, out_flit=0, rr_ptr=0, flit_count=0. req_grant is 0 while rst=1.
- slot_free = !out_valid | out_ready.
- grant_ok = arb_en & slot_free & (|req_valid) & !rst.
- Round-robin selection:
  - Search indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first with req_valid=1 wins.
  - req_grant is asserted only for the winner, and only when grant_ok.
  - req_grant never depends on req_bundle.
- On a grant edge (winner w):
  - out_flit[31:0] = payload, [35:32] = op, [37:36] = algtype, [45:38] = tag, [53:46] = contextId, [62:54] = rank.
  - out_flit[65:63] = my_x, [68:66] = my_y, [71:69] = my_z.
  - out_flit[74:72] = dst_x, [77:75] = dst_y, [80:78] = dst_z.
  - out_flit[81] = 1.
  - out_valid=1; rr_ptr = (w+1) mod NUM_REQ.
- Latency: the request is granted in cycle N and appears on out_valid/out_flit in cycle N+1.
- Throughput: one flit per cycle while out_ready stays high (simultaneous drain and refill).
- When out_valid=1 and out_ready=1 with no grant: out_valid clears to 0 next cycle; out_flit holds its last value.
- Backpressure: while out_valid=1 and out_ready=0, out_flit and out_valid are held stable, no grant issues, and rr_ptr is unchanged.
- No-request cycles leave rr_ptr unchanged (pointer advances only on a grant).
- flit_count increments by 1 on each out_valid&out_ready edge and wraps from 2^CNT_W-1 to 0.
- State machine, 2 states:
  - EMPTY (out_valid=0) goes to FULL on a grant.
  - FULL goes to EMPTY on drain without grant.
  - FULL stays FULL on drain with grant, or while stalled.
- arb_en falling while FULL: the held flit still drains; no further grants until arb_en=1.
- Reset mid-operation: a held flit is discarded with no drain. Requesters must treat rst as a cancellation of un-granted requests.
- Loopback (dst equal to my_*) is emitted unchanged; routing is downstream's concern.
- Each request is granted at most once per handshake; a requester holding req_valid high gets consecutive grants only when it is the sole requester or rotation returns to it.

Test Plan:
- Single request: req_valid=0001, bundle payload=0xDEADBEEF, op=3, tag=0x5A, dst=(1,2,3), my=(4,5,6), out_ready=1 -> req_grant=0001 in the same cycle; next cycle out_valid=1 with out_flit[31:0]=DEADBEEF, [65:63]=4, [80:78]=3, [81]=1; flit_count=1 one cycle later.
- Fairness: req_valid=1111 held, out_ready=1 -> grants 0001, 0010, 0100, 1000, 0001, ... one per cycle; flit_count=8 after 8 transfers.
- Backpressure: out_ready=0 for 5 cycles with all requests pending -> exactly one grant; out_flit stable; rr_ptr frozen. out_ready=1 then resumes at the next index.
- Sparse rotation: rr_ptr=2, req_valid=0011 -> grant 0001; rr_ptr becomes 1; next grant 0010.
- Control: arb_en=0 with requests pending -> req_grant=0 and a pending flit drains. rst asserted while out_valid=1 -> out_valid=0, flit_count=0, rr_ptr=0 the next cycle.
- Counter wrap: with CNT_W=4, drive 17 transfers -> flit_count=1.

Source files
------------

// File: rtl/inject_arbiter.sv
// Round-robin injection arbiter: picks one local requester per cycle, builds an
// 82-bit flit stamped with this node's coordinates, and holds it in a one-entry output register.
module inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2,
    parameter int REQ_W   = 72,
    parameter int FLIT_W  = 82,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [2:0]               my_x,
    input  logic [2:0]               my_y,
    input  logic [2:0]               my_z,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] req_bundle,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         flit_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [PTR_W:0]     w_idx;
    logic [FLIT_W-1:0]  r_flit;
    logic [FLIT_W-1:0]  w_flit;
    logic [CNT_W-1:0]   r_count;
    logic               w_found;
    logic               w_slot_free;
    logic               w_grant_ok;
    logic               w_drain;
    logic [REQ_W-1:0]   w_bundle [NUM_REQ];
    logic [REQ_W-1:0]   w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_bundle[gi]  = req_bundle[gi*REQ_W +: REQ_W];
            assign req_grant[gi] = w_grant_ok && (w_win == PTR_W'(gi));
        end
    endgenerate

    // Scan from the pointer, wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_REQ))
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            if (!w_found && req_valid[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end
        end
    end

    assign out_valid   = (r_state == ST_FULL);
    assign w_slot_free = !out_valid || out_ready;
    assign w_grant_ok  = arb_en && w_slot_free && w_found && !rst;
    assign w_drain     = out_valid && out_ready;
    assign w_ptr_next  = (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

    // Request dst fields move above the source coordinates; the low 63 bits pass straight through.
    assign w_sel  = w_bundle[w_win];
    assign w_flit = FLIT_W'({1'b1, w_sel[71:63], my_z, my_y, my_x, w_sel[62:0]});

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant_ok) w_state_next = ST_FULL;
            ST_FULL:  if (w_grant_ok) w_state_next = ST_FULL;
                      else if (out_ready) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_flit   <= '0;
            r_rr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_ok) begin
                r_flit   <= w_flit;
                r_rr_ptr <= w_ptr_next;
            end
            if (w_drain)
                r_count <= r_count + 1'b1;
        end
    end

    assign out_flit   = r_flit;
    assign flit_count = r_count;

endmodule
